// File: rtl/fp32_seq_divider.sv
// Iterative single-precision divider: radix-2 restoring mantissa loop behind a
// start/done handshake, with a one-cycle bypass for special operands.
module fp32_seq_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int QBITS      = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] float_num1,
  input  logic [DATA_WIDTH-1:0] float_num2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  invalid,
  output logic                  div_by_zero,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [24:0]             rem_q, rem_d;
  logic [23:0]             dvs_q, dvs_d;
  logic [QBITS-1:0]        quo_q, quo_d;
  logic signed [9:0]       exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    inv_q, inv_d;
  logic                    dbz_q, dbz_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  // Operand classification; denormals fold into zero.
  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic        s_res;
  logic        nan1, nan2, inf1, inf2, zero1, zero2, is_special;
  logic [DATA_WIDTH-1:0] spec_out;
  logic        spec_inv, spec_dbz;

  always_comb begin
    e1    = float_num1[30:23];
    e2    = float_num2[30:23];
    f1    = float_num1[22:0];
    f2    = float_num2[22:0];
    s_res = float_num1[31] ^ float_num2[31];
    nan1  = (e1 == 8'hFF) && (f1 != '0);
    nan2  = (e2 == 8'hFF) && (f2 != '0);
    inf1  = (e1 == 8'hFF) && (f1 == '0);
    inf2  = (e2 == 8'hFF) && (f2 == '0);
    zero1 = (e1 == 8'h00);
    zero2 = (e2 == 8'h00);
    is_special = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;

    spec_out = '0;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      spec_out = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end else if (inf1) begin
      spec_out = {s_res, 8'hFF, 23'd0};
    end else if (inf2) begin
      spec_out = {s_res, 31'd0};
    end else if (zero2) begin
      spec_out = {s_res, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end else begin
      spec_out = {s_res, 31'd0};
    end
  end

  // Trial subtraction for one restoring-division step.
  logic [25:0] trial;

  always_comb begin
    trial = {1'b0, rem_q} - {2'b00, dvs_q};
  end

  // Normalisation and round-to-nearest-even of the finished quotient.
  logic              norm;
  logic [22:0]       frac_n;
  logic              guard, rbit, sticky, rup;
  logic [23:0]       frac_sum;
  logic signed [9:0] exp_r;

  always_comb begin
    norm     = quo_q[QBITS-1];
    frac_n   = norm ? quo_q[QBITS-2:2] : quo_q[QBITS-3:1];
    guard    = norm ? quo_q[1] : quo_q[0];
    rbit     = norm & quo_q[0];
    sticky   = |rem_q;
    rup      = guard & (rbit | sticky | frac_n[0]);
    frac_sum = {1'b0, frac_n} + {23'd0, rup};
    exp_r    = exp_q - {9'd0, ~norm} + {9'd0, frac_sum[23]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    inv_d   = inv_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          sign_d = s_res;
          inv_d  = 1'b0;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (is_special) begin
            out_d   = spec_out;
            inv_d   = spec_inv;
            dbz_d   = spec_dbz;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = {2'b01, f1};
            dvs_d   = {1'b1, f2};
            quo_d   = '0;
            cnt_d   = '0;
            exp_d   = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
            state_d = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        quo_d = {quo_q[QBITS-2:0], ~trial[25]};
        rem_d = (trial[25] ? rem_q : trial[24:0]) << 1;
        if (cnt_q == CW'(QBITS - 1)) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ROUND: begin
        if (exp_r >= 10'sd255) begin
          out_d = {sign_q, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end else if (exp_r <= 10'sd0) begin
          out_d = {sign_q, 31'd0};
          unf_d = 1'b1;
        end else begin
          out_d = {sign_q, exp_r[7:0], frac_sum[22:0]};
        end
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out         = out_q;
  assign invalid     = inv_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_fp32_seq_divider.sv
// Self-checking bench for fp32_seq_divider: directed vector table, handshake
// corner sequences, and random operands against an integer-division model.
module tb_fp32_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] n1, n2;
  logic        busy, done;
  logic [31:0] out;
  logic        invalid, div_by_zero, overflow, underflow;

  int checks = 0;
  int errors = 0;

  fp32_seq_divider #(.DATA_WIDTH(32), .QBITS(26)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .float_num1(n1),
    .float_num2(n2),
    .busy(busy),
    .done(done),
    .out(out),
    .invalid(invalid),
    .div_by_zero(div_by_zero),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic [3:0]  exp_flags;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  // Reference: exact integer quotient, then round-to-nearest-even on it.
  // Result packs {special, out, invalid, div_by_zero, overflow, underflow}.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint fa, fb, m1, m2, num, q, r, mant;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    fa     = longint'(a[22:0]);
    fb     = longint'(b[22:0]);
    a_nan  = (ea == 255) && (fa != 0);
    b_nan  = (eb == 255) && (fb != 0);
    a_inf  = (ea == 255) && (fa == 0);
    b_inf  = (eb == 255) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      return {1'b1, 32'h7FC0_0000, 4'b1000};
    if (a_inf)  return {1'b1, s, 8'hFF, 23'd0, 4'b0000};
    if (b_inf)  return {1'b1, s, 31'd0, 4'b0000};
    if (b_zero) return {1'b1, s, 8'hFF, 23'd0, 4'b0100};
    if (a_zero) return {1'b1, s, 31'd0, 4'b0000};
    m1 = fa + (64'sd1 << 23);
    m2 = fb + (64'sd1 << 23);
    e  = ea - eb + 127;
    if (m1 >= m2) begin
      num = m1 << 24;
    end else begin
      num = m1 << 25;
      e   = e - 1;
    end
    q    = num / m2;
    r    = num % m2;
    mant = q >> 1;
    if ((q % 2 == 1) && ((r != 0) || (mant % 2 == 1)))
      mant = mant + 1;
    if (mant == (64'sd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'd0, 4'b0010};
    if (e <= 0)   return {1'b0, s, 31'd0, 4'b0001};
    return {1'b0, s, 8'(e), 23'(mant), 4'b0000};
  endfunction

  function automatic logic [31:0] gen();
    int unsigned k;
    logic [31:0] v;
    k = $urandom_range(0, 7);
    v = $urandom;
    if (k == 0) return v;
    if (k == 1) return {v[31], 8'h00, v[22:0]};
    if (k == 2) return {v[31], 8'hFF, (v[0] ? 23'd0 : v[22:0])};
    return {v[31], 8'($urandom_range(1, 254)), v[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] o, output logic [3:0] f, output int lat);
    @(negedge clk);
    start = 1'b1;
    n1    = a;
    n2    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    n1    = $urandom;
    n2    = $urandom;
    lat   = 1;
    @(negedge clk);
    if (!done) chk("flags_cleared", {invalid, div_by_zero, overflow, underflow}, 4'b0000);
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", 1'b0, 1'b1);
    o = out;
    f = {invalid, div_by_zero, overflow, underflow};
  endtask

  initial begin
    logic [31:0] o;
    logic [3:0]  f;
    logic [36:0] m;
    int          lat;
    int          seen;

    vecs[0] = '{"half",      32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 4'b0000, 28};
    vecs[1] = '{"three",     32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 4'b0000, 28};
    vecs[2] = '{"third",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28};
    vecs[3] = '{"four_3rds", 32'h4000_0000, 32'h3FC0_0000, 32'h3FAA_AAAB, 4'b0000, 28};
    vecs[4] = '{"zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1};
    vecs[5] = '{"neg_by_0",  32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 1};
    vecs[6] = '{"by_ninf",   32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 1};
    vecs[7] = '{"overflow",  32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0010, 28};
    vecs[8] = '{"underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0001, 28};
    vecs[9] = '{"inf_inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, 1};

    rst   = 1'b1;
    start = 1'b0;
    n1    = '0;
    n2    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_out", out, 32'h0);
    chk("reset_flags", {invalid, div_by_zero, overflow, underflow}, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, o, f, lat);
      chk({vecs[i].name, "_out"}, o, vecs[i].exp_out);
      chk({vecs[i].name, "_flags"}, f, vecs[i].exp_flags);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
    end

    // Abort a normal divide mid-loop with reset.
    @(negedge clk);
    start = 1'b1;
    n1    = 32'h3F80_0000;
    n2    = 32'h4040_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_out", out, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    do_op(32'h4040_0000, 32'h3F80_0000, o, f, lat);
    chk("after_abort_out", o, 32'h4040_0000);
    chk("after_abort_lat", lat, 28);

    // start held high with changing operands; next accept right after done.
    @(negedge clk);
    start = 1'b1;
    n1    = 32'h3F80_0000;
    n2    = 32'h4040_0000;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 60) begin
      n1 = $urandom;
      n2 = $urandom;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("hold_out", out, 32'h3EAA_AAAB);
    chk("hold_lat", lat, 28);
    n1 = 32'h0;
    n2 = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_busy", busy, 1'b0);
    chk("hold_idle_done", done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_next_done", done, 1'b1);
    chk("hold_next_out", out, 32'h7FC0_0000);
    chk("hold_next_inv", invalid, 1'b1);
    start = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = gen();
      b = gen();
      m = model(a, b);
      do_op(a, b, o, f, lat);
      chk("rand_out", o, m[35:4]);
      chk("rand_flags", f, m[3:0]);
      chk("rand_lat", lat, m[36] ? 1 : 28);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
